// File: rtl/clic_pkg.sv
// Shared types for the CLIC interrupt gateway: trigger modes and per-source gateway states.
package clic_pkg;

  typedef enum logic [1:0] {
    LEVEL_POS = 2'b00,
    EDGE_POS  = 2'b01,
    LEVEL_NEG = 2'b10,
    EDGE_NEG  = 2'b11
  } trig_e;

  typedef enum logic [1:0] {
    ARMING  = 2'b00,
    IDLE    = 2'b01,
    PENDING = 2'b10
  } gw_state_e;

endpackage

// File: rtl/clic_gateway_cell.sv
// One interrupt source: polarity qualification, edge detection and the pending-bit FSM.
module clic_gateway_cell
  import clic_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       arm_done_i,
  input  logic       src_i,
  input  logic [1:0] trig_i,
  input  logic       sw_we_i,
  input  logic       sw_wdata_i,
  input  logic       claim_i,
  output logic       ip_o
);

  gw_state_e state_q, state_d;
  logic      prev_q, edge_mode_q;
  logic      qlvl_c, edge_c, pend_c;

  always_comb begin
    state_d = state_q;
    qlvl_c  = src_i ^ trig_i[1];
    edge_c  = qlvl_c & ~prev_q & (state_q != ARMING);
    // Entering edge mode starts from IDLE so a held level is not mistaken for a latched edge.
    pend_c  = edge_mode_q & (state_q == PENDING);
    if (claim_i)  pend_c = 1'b0;
    if (sw_we_i)  pend_c = sw_wdata_i;
    if (edge_c)   pend_c = 1'b1;

    if ((state_q == ARMING) && !arm_done_i) begin
      state_d = ARMING;
    end else if (!trig_i[0]) begin
      state_d = qlvl_c ? PENDING : IDLE;
    end else if (state_q == ARMING) begin
      state_d = IDLE;
    end else begin
      state_d = pend_c ? PENDING : IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ARMING;
      prev_q      <= 1'b0;
      edge_mode_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= qlvl_c;
      edge_mode_q <= trig_i[0];
    end
  end

  assign ip_o = (state_q == PENDING);

endmodule

// File: rtl/clic_gateway.sv
// CLIC interrupt gateway: claim decode, arming timer and one gateway cell per source.
// Optional input synchronizer enabled by defining CLIC_GATEWAY_SYNC_EN.
module clic_gateway
  import clic_pkg::*;
#(
  parameter int unsigned N_SOURCE = 32,
  parameter int unsigned SRC_IDW  = $clog2(N_SOURCE)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_SOURCE-1:0]      intr_src_i,
  input  logic [N_SOURCE-1:0][1:0] trig_i,
  input  logic [N_SOURCE-1:0]      ie_i,
  input  logic [N_SOURCE-1:0]      sw_we_i,
  input  logic [N_SOURCE-1:0]      sw_wdata_i,
  input  logic                     claim_valid_i,
  input  logic [SRC_IDW-1:0]       claim_id_i,
  output logic [N_SOURCE-1:0]      ip_o,
  output logic [N_SOURCE-1:0]      ip_ie_o
);

  logic [N_SOURCE-1:0] src_c;
  logic [1:0]          arm_cnt_q;
  logic                arm_done_c;

`ifdef CLIC_GATEWAY_SYNC_EN
  localparam int unsigned ARM_CYCLES = 3;

  logic [N_SOURCE-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= intr_src_i;
      sync2_q <= sync1_q;
    end
  end

  assign src_c = sync2_q;
`else
  localparam int unsigned ARM_CYCLES = 1;

  assign src_c = intr_src_i;
`endif

  // Arming holds until the source path carries post-reset samples.
  assign arm_done_c = (arm_cnt_q == 2'(ARM_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      arm_cnt_q <= 2'd0;
    end else if (!arm_done_c) begin
      arm_cnt_q <= arm_cnt_q + 2'd1;
    end
  end

  for (genvar i = 0; i < N_SOURCE; i++) begin : g_src
    logic claim_c;

    assign claim_c = claim_valid_i & (claim_id_i == SRC_IDW'(i));

    clic_gateway_cell u_cell (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .arm_done_i (arm_done_c),
      .src_i      (src_c[i]),
      .trig_i     (trig_i[i]),
      .sw_we_i    (sw_we_i[i]),
      .sw_wdata_i (sw_wdata_i[i]),
      .claim_i    (claim_c),
      .ip_o       (ip_o[i])
    );
  end

  assign ip_ie_o = ip_o & ie_i;

endmodule

// File: tb/tb_clic_gateway.sv
// Self-checking bench for clic_gateway: directed scenarios plus random traffic against a behavioural model.
module tb_clic_gateway;
  import clic_pkg::*;

  localparam int unsigned NS  = 24;
  localparam int unsigned IDW = 5;
`ifdef CLIC_GATEWAY_SYNC_EN
  localparam int ARM = 3;
`else
  localparam int ARM = 1;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NS-1:0]       src, ie, sw_we, sw_wdata;
  logic [NS-1:0][1:0]  trig;
  logic                claim_v;
  logic [IDW-1:0]      claim_id;
  logic [NS-1:0]       ip_o, ip_ie_o;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned n_fail = 0;

  // Reference state: pending bits, last qualified level, last mode, arming cycles left.
  logic [NS-1:0] m_ip, m_prev, m_em;
  int            m_arm;
`ifdef CLIC_GATEWAY_SYNC_EN
  logic [NS-1:0] m_s1, m_s2;
`endif

  always #5 clk = ~clk;

  clic_gateway #(.N_SOURCE(NS), .SRC_IDW(IDW)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .intr_src_i    (src),
    .trig_i        (trig),
    .ie_i          (ie),
    .sw_we_i       (sw_we),
    .sw_wdata_i    (sw_wdata),
    .claim_valid_i (claim_v),
    .claim_id_i    (claim_id),
    .ip_o          (ip_o),
    .ip_ie_o       (ip_ie_o)
  );

  task automatic chk(input string tag, input logic [NS-1:0] obs, input logic [NS-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Apply one clock edge of the gateway rules to the reference state.
  task automatic model_edge();
    logic [NS-1:0] eff, nip;
    logic          q;
    if (!rst_n) begin
      m_ip   = '0;
      m_prev = '0;
      m_em   = '0;
      m_arm  = ARM;
`ifdef CLIC_GATEWAY_SYNC_EN
      m_s1   = '0;
      m_s2   = '0;
`endif
      return;
    end
`ifdef CLIC_GATEWAY_SYNC_EN
    eff = m_s2;
`else
    eff = src;
`endif
    nip = '0;
    for (int i = 0; i < NS; i++) begin
      q = eff[i] ^ trig[i][1];
      if (m_arm > 1) begin
        nip[i] = 1'b0;
      end else if (!trig[i][0]) begin
        nip[i] = q;
      end else if (m_arm == 1) begin
        nip[i] = 1'b0;
      end else begin
        nip[i] = m_em[i] ? m_ip[i] : 1'b0;
        if (claim_v && (int'(claim_id) == i)) nip[i] = 1'b0;
        if (sw_we[i]) nip[i] = sw_wdata[i];
        if (q && !m_prev[i]) nip[i] = 1'b1;
      end
      m_prev[i] = q;
      m_em[i]   = trig[i][0];
    end
    m_ip = nip;
    if (m_arm > 0) m_arm--;
`ifdef CLIC_GATEWAY_SYNC_EN
    m_s2 = m_s1;
    m_s1 = src;
`endif
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, "_ip"}, ip_o, m_ip);
    chk({tag, "_ipie"}, ip_ie_o, m_ip & ie);
  endtask

  initial begin
    rst_n    = 1'b0;
    src      = '1;
    ie       = '1;
    sw_we    = '0;
    sw_wdata = '0;
    claim_v  = 1'b0;
    claim_id = '0;
    for (int i = 0; i < NS; i++) trig[i] = EDGE_POS;
    m_ip = '0; m_prev = '0; m_em = '0; m_arm = ARM;
`ifdef CLIC_GATEWAY_SYNC_EN
    m_s1 = '0; m_s2 = '0;
`endif

    repeat (3) tick("reset");
    chk("reset_const", ip_o, '0);
    chk("reset_ipie_const", ip_ie_o, '0);

`ifndef CLIC_GATEWAY_SYNC_EN
    // Lines high through reset: no edge after release; fall then rise on src 7.
    rst_n = 1'b1;
    tick("arm");
    tick("arm2");
    chk("no_edge_after_release", ip_o, '0);
    src[7] = 1'b0; tick("s7_fall");
    src[7] = 1'b1; tick("s7_rise");
    chk("only_src7", ip_o, NS'(1 << 7));
    claim_v = 1'b1; claim_id = 5'd7; tick("claim7");
    claim_v = 1'b0;
    chk("claim7_clear", ip_o, '0);

    // Edge pulse on src 3 is latched, then claimed.
    src = '0; tick("all_low");
    src[3] = 1'b1; tick("s3_rise");
    chk1("s3_set", ip_o[3], 1'b1);
    tick("s3_high");
    src[3] = 1'b0; tick("s3_low");
    tick("s3_hold");
    chk1("s3_hold", ip_o[3], 1'b1);
    claim_v = 1'b1; claim_id = 5'd3; tick("claim3");
    claim_v = 1'b0;
    chk1("s3_claimed", ip_o[3], 1'b0);

    // Edge and claim of src 0 in the same cycle: edge wins.
    src[0] = 1'b1; claim_v = 1'b1; claim_id = 5'd0; tick("s0_edge_claim");
    claim_v = 1'b0;
    chk1("s0_edge_wins", ip_o[0], 1'b1);
    claim_v = 1'b1; tick("claim0");
    claim_v = 1'b0;
    chk1("s0_claimed", ip_o[0], 1'b0);

    // Src 5 level-negative follows the inverted line; sw writes ignored.
    trig[5] = LEVEL_NEG; src[5] = 1'b1; tick("s5_inactive");
    chk1("s5_low", ip_o[5], 1'b0);
    src[5] = 1'b0; tick("s5_active");
    chk1("s5_follow", ip_o[5], 1'b1);
    sw_we[5] = 1'b1; sw_wdata[5] = 1'b0; tick("s5_sw0");
    sw_we[5] = 1'b0;
    chk1("s5_sw_ignored", ip_o[5], 1'b1);
    src[5] = 1'b1; tick("s5_release");
    chk1("s5_release", ip_o[5], 1'b0);

    // Src 2 level->edge while high drops pending; ie masks only ip_ie_o.
    trig[2] = LEVEL_POS; src[2] = 1'b1; tick("s2_level");
    ie[2] = 1'b0; tick("s2_masked");
    chk1("s2_ip_unmasked", ip_o[2], 1'b1);
    chk1("s2_ipie_masked", ip_ie_o[2], 1'b0);
    trig[2] = EDGE_POS; tick("s2_to_edge");
    chk1("s2_no_spurious", ip_o[2], 1'b0);
    ie[2] = 1'b1;

    // Out-of-range claim id, then edge->level switch.
    src[9] = 1'b1; tick("s9_rise");
    claim_v = 1'b1; claim_id = 5'd25; tick("claim_oor");
    claim_v = 1'b0;
    chk1("claim_oor_noop", ip_o[9], 1'b1);
    trig[9] = LEVEL_POS; src[9] = 1'b0; tick("s9_to_level");
    chk1("s9_level_low", ip_o[9], 1'b0);

    // sw set vs claim same cycle: sw wins. Edge vs sw clear: edge wins.
    sw_we[11] = 1'b1; sw_wdata[11] = 1'b1; claim_v = 1'b1; claim_id = 5'd11; tick("s11_sw_claim");
    sw_we[11] = 1'b0; claim_v = 1'b0;
    chk1("s11_sw_wins", ip_o[11], 1'b1);
    src[12] = 1'b1; sw_we[12] = 1'b1; sw_wdata[12] = 1'b0; tick("s12_edge_sw0");
    sw_we[12] = 1'b0;
    chk1("s12_edge_wins", ip_o[12], 1'b1);

    // Reset mid-pending clears; lines already high report nothing after release.
    rst_n = 1'b0; tick("mid_reset");
    chk("mid_reset_clear", ip_o, '0);
    rst_n = 1'b1; tick("rearm");
    tick("rearm2");
    chk("rearm_quiet", ip_o, '0);
`else
    rst_n = 1'b1;
    repeat (4) tick("sync_arm");
    src = '0; repeat (3) tick("sync_low");
    src[1] = 1'b1; tick("sync_rise");
    chk1("sync_lat1", ip_o[1], 1'b0);
    tick("sync_lat2");
    chk1("sync_lat2", ip_o[1], 1'b0);
    tick("sync_lat3");
    chk1("sync_set", ip_o[1], 1'b1);
    claim_v = 1'b1; claim_id = IDW'(NS); tick("sync_claim_oor");
    claim_v = 1'b0;
    chk1("sync_claim_oor", ip_o[1], 1'b1);
`endif

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      rst_n    = ($urandom_range(0, 99) != 0);
      src      = NS'($urandom);
      ie       = NS'($urandom);
      sw_we    = NS'($urandom & $urandom & $urandom);
      sw_wdata = NS'($urandom);
      claim_v  = ($urandom_range(0, 3) == 0);
      claim_id = IDW'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < NS; i++) trig[i] = 2'($urandom);
      end
      tick("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/clic_gateway.md
CLIC_GATEWAY -- requirements
Module: clic_gateway

Interface
REQ-001 SHALL have parameter N_SOURCE, default 32: number of interrupt sources.
REQ-002 SHALL have parameter SRC_IDW, default $clog2(N_SOURCE): width of a source ID.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state SHALL be on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port intr_src_i, input, N_SOURCE bits: raw interrupt lines.
REQ-006 SHALL have port trig_i, input, 2 bits x N_SOURCE: per-source trigger mode, where [0]=edge and [1]=negative polarity.
REQ-007 SHALL have port ie_i, input, N_SOURCE bits: per-source enable.
REQ-008 SHALL have port sw_we_i, input, N_SOURCE bits: software write strobe for the pending bit.
REQ-009 SHALL have port sw_wdata_i, input, N_SOURCE bits: software pending write data.
REQ-010 SHALL have port claim_valid_i, input, 1 bit: the core acknowledges a taken interrupt.
REQ-011 SHALL have port claim_id_i, input, SRC_IDW bits: ID of the acknowledged source.
REQ-012 SHALL have port ip_o, output, N_SOURCE bits: registered pending bits, fed to the register file write-back.
REQ-013 SHALL have port ip_ie_o, output, N_SOURCE bits: ip_o AND ie_i, fed to the arbiter.

Function
REQ-014 SHALL form the qualified level per source as src XOR trig_i[i][1].
REQ-015 In level mode (trig[0]=0), ip SHALL follow the qualified level with 1-cycle latency; sw_we SHALL be ignored; claim SHALL be ignored.
REQ-016 In edge mode, a 0->1 transition of the qualified level SHALL set ip in the next cycle; ip SHALL then hold until cleared.
REQ-017 Edge mode: sw_we with sw_wdata=1 SHALL set ip, and with sw_wdata=0 SHALL clear ip, next cycle.
REQ-018 Edge mode: claim_valid_i with claim_id_i=i SHALL clear ip[i] next cycle.
REQ-019 On a same-cycle detected edge and claim of the same source, the edge SHALL win and ip SHALL stay 1.
REQ-020 On a same-cycle detected edge and sw write of 0, the edge SHALL win.
REQ-021 On a same-cycle sw write and claim, the sw write SHALL win.
REQ-022 A claim_id_i >= N_SOURCE SHALL have no effect.
REQ-023 A previous-level register per source SHALL update every cycle, in every mode, so that a level->edge mode switch raises no spurious edge unless a true 0->1 transition occurs afterwards.
REQ-024 When switching edge->level, ip SHALL equal the qualified level from the next cycle.
REQ-025 A polarity change SHALL be detected as an edge only if the resulting qualified level transitions 0->1 relative to the previous-level register.
REQ-026 Per-source FSM: ARMING -> IDLE -> PENDING.
- ARMING lasts the first cycle after reset release; edge detection is disabled and prev-level loads.
- IDLE moves to PENDING on an edge or sw set.
- PENDING moves to IDLE on claim or sw clear.
- Level mode bypasses the FSM and forces the IDLE/PENDING encoding from the level.
REQ-027 ip_ie_o SHALL be combinational from ip_o and ie_i; ie_i SHALL NOT affect ip capture.

Reset
REQ-028 While rst_ni=0 at a clock edge: ip_o=0, prev-level=0, FSM=ARMING; ip_ie_o=0.
REQ-029 Reset asserted mid-pending SHALL clear ip on that edge; no edge SHALL be reported in the first cycle after release, even if a line is already high.

Configuration
REQ-030 With CLIC_GATEWAY_SYNC_EN defined, intr_src_i SHALL pass a 2-flop synchronizer (reset 0) before REQ-014, adding 2 cycles of latency and keeping ARMING until the synchronizer is filled (3 cycles).
REQ-031 Without CLIC_GATEWAY_SYNC_EN, intr_src_i SHALL be used directly and ARMING SHALL last 1 cycle.

Structure
REQ-032 Package clic_pkg SHALL hold the trig_e typedef: LEVEL_POS=00, EDGE_POS=01, LEVEL_NEG=10, EDGE_NEG=11.
REQ-033 Package clic_pkg SHALL hold the gw_state_e typedef (ARMING, IDLE, PENDING).
REQ-034 Sub-module clic_gateway_cell SHALL implement one source and be instantiated N_SOURCE times; claim decode SHALL remain in the top.

Verification (no sync macro unless stated)
REQ-035 Src 3 in EDGE_POS, pulse high cycles 10-11 -> ip_o[3]=1 from cycle 11; claim id 3 at cycle 20 -> ip_o[3]=0 at cycle 21.
REQ-036 Src 5 in LEVEL_NEG, line low for cycles 4-8 -> ip_o[5]=1 for cycles 5-9; sw_we with data 0 at cycle 6 -> no effect.
REQ-037 Src 0 in EDGE_POS, rising edge and claim id 0 in the same cycle -> ip_o[0] stays 1.
REQ-038 All lines high throughout reset, all edge mode -> ip_o=0 after release; a later fall then rise on src 7 -> only ip_o[7]=1.
REQ-039 Src 2 switched LEVEL_POS -> EDGE_POS while the line is high -> ip_o[2] falls to 0 with no set; ie_i[2]=0 with ip=1 -> ip_ie_o[2]=0.
REQ-040 With CLIC_GATEWAY_SYNC_EN, rising edge at cycle 10 on src 1 -> ip_o[1]=1 at cycle 13; claim_id=N_SOURCE -> no change.
